mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter, CPU strict priority over video bursts.
// Define MEM_ARB_FAIR_EN to force a video byte after STARVE_LIMIT consecutive CPU wins.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [7:0]        vid_len,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic              vid_done,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [7:0] cnt;
  logic force_vid, cpu_iss, vid_iss, last;
  logic p_cpu, p_vid, p_last;
`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  logic [SW-1:0] starve;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else starve <= (state == BURST && cpu_iss) ? starve + 1'b1 : '0;
  assign force_vid = state == BURST && starve >= SW'(STARVE_LIMIT);
`else
  assign force_vid = 1'b0 && STARVE_LIMIT > 0;
`endif
  // issue decisions are gated by rst_n so the command outputs read 0 during reset
  always_comb begin
    cpu_iss   = rst_n && cpu_req && !force_vid;
    vid_iss   = rst_n && state == BURST && !cpu_iss;
    last      = vid_iss && cnt == 8'd1;
    vid_gnt   = rst_n && state == IDLE && vid_req;
    cpu_gnt   = cpu_iss;
    state_nx  = vid_gnt ? BURST : last ? IDLE : state;
    mem_addr  = cpu_iss ? cpu_addr : vid_iss ? ptr : '0;
    mem_wdata = (cpu_iss && cpu_we) ? cpu_wdata : '0;
    mem_wr    = cpu_iss && cpu_we;
    mem_rd    = (cpu_iss && !cpu_we) || vid_iss;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (vid_gnt) begin
        ptr <= vid_addr;
        cnt <= vid_len;
      end else if (vid_iss) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  // memory returns data the cycle after the command; it is registered once more
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_cpu      <= 1'b0;
      p_vid      <= 1'b0;
      p_last     <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rvalid <= 1'b0;
      vid_done   <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      p_cpu      <= cpu_iss && !cpu_we;
      p_vid      <= vid_iss;
      p_last     <= last;
      cpu_rvalid <= p_cpu;
      vid_rvalid <= p_vid;
      vid_done   <= p_last;
      if (p_cpu) cpu_rdata <= mem_rdata;
      if (p_vid) vid_rdata <= mem_rdata;
    end
endmodule
